// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - loads a program into instruction memory, then steps through it.
// The datapath stream is consumed directly from memory read data; this block only steers addresses.
module inst_sequencer #(
    parameter int          INST_W       = 32,
    parameter int          ADDR_W       = 10,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [INST_W-1:0] host_data,
    input  logic              host_last,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [ADDR_W-1:0] inst_write_addr,
    output logic [INST_W-1:0] inst_write_data,
    output logic              inst_write_enable,
    output logic              exec_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ONE_A      = 1;
    localparam logic [ADDR_W:0]   ONE_L      = 1;
    localparam logic [ADDR_W-1:0] WPTR_MAX   = '1;
    localparam logic [3:0]        DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              load_error_q, load_error_d;
    logic              aborted_q, aborted_d;
    logic [3:0]        drain_q, drain_d;

    logic       is_halt;
    logic       in_range;
    logic       last_pc;
    logic       issue;
    logic       unused_inst_bits;

    assign is_halt          = (inst_data[INST_W-1 -: 4] == HALT_OPCODE);
    assign in_range         = ({1'b0, pc_q} < prog_len_q);
    assign last_pc          = (({1'b0, pc_q} + ONE_L) == prog_len_q);
    assign unused_inst_bits = ^inst_data[INST_W-5:0];

    assign host_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy       = (state_q != S_IDLE);
    assign aborted    = aborted_q;
    assign prog_len   = prog_len_q;
    assign load_error = load_error_q;

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        wptr_d            = wptr_q;
        prog_len_d        = prog_len_q;
        load_error_d      = load_error_q;
        drain_d           = drain_q;
        aborted_d         = 1'b0;
        inst_write_enable = 1'b0;
        inst_write_addr   = wptr_q;
        inst_write_data   = host_data;
        inst_addr         = '0;
        issue             = 1'b0;
        exec_valid        = 1'b0;
        done              = 1'b0;

        // Abort outranks every other request, but is meaningless while idle.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
            if (state_q == S_LOAD) begin
                prog_len_d = '0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (host_valid) begin
                        inst_write_enable = 1'b1;
                        inst_write_addr   = '0;
                        wptr_d            = ONE_A;
                        load_error_d      = 1'b0;
                        if (host_last) begin
                            prog_len_d = ONE_L;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else if (start && (prog_len_q != '0)) begin
                        state_d = S_RUN;
                        pc_d    = '0;
                    end
                end
                S_LOAD: begin
                    if (host_valid) begin
                        inst_write_enable = 1'b1;
                        wptr_d            = wptr_q + ONE_A;
                        if (host_last) begin
                            prog_len_d = {1'b0, wptr_q} + ONE_L;
                            state_d    = S_IDLE;
                        end else if (wptr_q == WPTR_MAX) begin
                            prog_len_d   = {1'b0, wptr_q} + ONE_L;
                            load_error_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end
                end
                S_RUN: begin
                    // Address one ahead on consume so the next word lands as pc advances.
                    inst_addr  = pc_q;
                    issue      = in_range && !is_halt;
                    exec_valid = issue;
                    if (issue && !stall) begin
                        pc_d      = pc_q + ONE_A;
                        inst_addr = pc_q + ONE_A;
                        if (last_pc) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end else if (is_halt && !stall) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            wptr_q       <= '0;
            prog_len_q   <= '0;
            load_error_q <= 1'b0;
            aborted_q    <= 1'b0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wptr_q       <= wptr_d;
            prog_len_q   <= prog_len_d;
            load_error_q <= load_error_d;
            aborted_q    <= aborted_d;
            drain_q      <= drain_d;
        end
    end

endmodule
